// File: rtl/sa_pkg.sv
// Shared types for the systolic partial-sum accumulation buffer: FSM state
// encoding, default accumulator width and the default psum row type.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } psum_state_e;

  localparam int SA_ACC_WIDTH = 32;
  localparam int SA_COL       = 3;

  typedef logic [SA_COL-1:0][SA_ACC_WIDTH-1:0] psum_row_t;

endpackage

// File: rtl/sa_sat_add.sv
// Single-element signed adder for psum accumulation.
// Saturates on signed overflow when SA_PSUM_SAT_EN is defined, wraps otherwise.
module sa_sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] raw;
  assign raw = a_i + b_i;

`ifdef SA_PSUM_SAT_EN
  // Overflow only when both operands share a sign that the result lost.
  logic ovf;
  assign ovf = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

  always_comb begin
    sum_o = raw;
    if (ovf) begin
      sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/sa_psum_accum.sv
// Partial-sum accumulation buffer: accumulates M-row tiles over K-tiles, then
// drains the M x N result as a valid/ready stream. Optional macro: SA_PSUM_SAT_EN.
module sa_psum_accum
  import sa_pkg::*;
#(
  parameter int COL       = 3,
  parameter int ACC_WIDTH = SA_ACC_WIDTH,
  parameter int DEPTH     = 16,
  parameter int TILE_W    = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [$clog2(DEPTH+1)-1:0]        num_rows_i,
  input  logic [TILE_W-1:0]                 num_tiles_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [COL-1:0][ACC_WIDTH-1:0]     in_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [COL-1:0][ACC_WIDTH-1:0]     out_data_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int RW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  psum_state_e state_q, state_d;

  logic [RW-1:0]     row_q;
  logic [TILE_W-1:0] tile_q;
  logic [RW-1:0]     num_rows_q;
  logic [TILE_W-1:0] num_tiles_q;

  logic [COL-1:0][ACC_WIDTH-1:0] mem [DEPTH];
  logic [COL-1:0][ACC_WIDTH-1:0] rd_row;
  logic [COL-1:0][ACC_WIDTH-1:0] add_row;
  logic [COL-1:0][ACC_WIDTH-1:0] wr_row;

  logic [AW-1:0] addr;
  logic          in_fire;
  logic          out_fire;
  logic          last_row;
  logic          last_tile;

  assign addr      = row_q[AW-1:0];
  assign in_fire   = in_valid_i && in_ready_o;
  assign out_fire  = out_valid_o && out_ready_i;
  assign last_row  = (row_q == num_rows_q - RW'(1));
  assign last_tile = (tile_q == num_tiles_q - TILE_W'(1));

  // Read port serves both the accumulate path and the drain stream.
  assign rd_row = mem[addr];

  for (genvar gi = 0; gi < COL; gi++) begin : g_add
    sa_sat_add #(.W(ACC_WIDTH)) u_add (
      .a_i  (rd_row[gi]),
      .b_i  (in_data_i[gi]),
      .sum_o(add_row[gi])
    );
  end

  // Tile 0 overwrites, so whatever the array held before start is never summed.
  assign wr_row = (tile_q == '0) ? in_data_i : add_row;

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      mem[addr] <= wr_row;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_rows_i == '0 || num_tiles_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire && last_row && last_tile) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && last_row) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_data_o  = rd_row;
        busy_o      = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q       <= '0;
      tile_q      <= '0;
      num_rows_q  <= '0;
      num_tiles_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_rows_q  <= num_rows_i;
            num_tiles_q <= num_tiles_i;
            row_q       <= '0;
            tile_q      <= '0;
          end
        end
        ACCUM: begin
          // Row wrap lands on 0, which is also the first drain row.
          if (in_fire) begin
            if (last_row) begin
              row_q  <= '0;
              tile_q <= tile_q + TILE_W'(1);
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            row_q <= last_row ? '0 : row_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_psum_accum.sv
// Self-checking bench for sa_psum_accum with randomized stimulus and a
// behavioural accumulation model (honours SA_PSUM_SAT_EN).
module tb_sa_psum_accum;

  localparam int COL    = 3;
  localparam int AW     = 16;
  localparam int DEPTH  = 16;
  localparam int TILE_W = 8;
  localparam int RW     = $clog2(DEPTH+1);
  localparam int MAXT   = 4;

  logic                        clk = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        start_i = 1'b0;
  logic [RW-1:0]               num_rows_i = '0;
  logic [TILE_W-1:0]           num_tiles_i = '0;
  logic                        in_valid_i = 1'b0;
  logic                        in_ready_o;
  logic [COL-1:0][AW-1:0]      in_data_i = '0;
  logic                        out_valid_o;
  logic                        out_ready_i = 1'b0;
  logic [COL-1:0][AW-1:0]      out_data_o;
  logic                        busy_o;
  logic                        done_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0]          stim [MAXT][DEPTH][COL];
  logic [COL-1:0][AW-1:0] got_q [$];

  always #5 clk = ~clk;

  sa_psum_accum #(.COL(COL), .ACC_WIDTH(AW), .DEPTH(DEPTH), .TILE_W(TILE_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .num_rows_i (num_rows_i),
    .num_tiles_i(num_tiles_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  // Signed 16-bit add on plain integers: clamp or wrap into the 16-bit range.
  function automatic int model_add(input int a, input int b);
    int s;
    s = a + b;
`ifdef SA_PSUM_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    if (s > 32767) s = s - 65536;
    if (s < -32768) s = s + 65536;
`endif
    return s;
  endfunction

  function automatic int model_elem(input int t, input int r, input int c);
    int acc;
    acc = int'($signed(stim[0][r][c]));
    for (int k = 1; k < t; k++) acc = model_add(acc, int'($signed(stim[k][r][c])));
    return acc;
  endfunction

  // Drives one complete job and collects drained rows into got_q; returns timing flags.
  task automatic run_job(input int m, input int t, input bit gap_in, input bit gap_out,
                         output bit ready_ok, output bit first_ov, output bit stable_ok,
                         output bit done_ok, output bit timeout);
    int idx, cyc;
    bit v, r, ov, ordy, have_held;
    logic [COL-1:0][AW-1:0] held;
    got_q.delete();
    timeout = 0; stable_ok = 1; have_held = 0; held = '0;
    @(negedge clk);
    start_i = 1'b1; num_rows_i = RW'(m); num_tiles_i = TILE_W'(t);
    @(negedge clk);
    start_i = 1'b0;
    ready_ok = in_ready_o && busy_o;
    idx = 0; cyc = 0;
    while (idx < m * t && !timeout) begin
      v = gap_in ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid_i = v;
      for (int c = 0; c < COL; c++)
        in_data_i[c] = v ? stim[idx / m][idx % m][c] : AW'($urandom);
      r = in_ready_o;
      @(negedge clk);
      if (v && r) idx++;
      cyc++;
      if (cyc > 5000) timeout = 1;
    end
    in_valid_i = 1'b0; in_data_i = '0;
    first_ov = out_valid_o;
    cyc = 0;
    while (got_q.size() < m && !timeout) begin
      ov = out_valid_o;
      if (have_held && ov && out_data_o !== held) stable_ok = 0;
      ordy = gap_out ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i = ordy;
      held = out_data_o;
      have_held = ov && !ordy;
      @(negedge clk);
      if (ov && ordy) got_q.push_back(held);
      cyc++;
      if (cyc > 5000) timeout = 1;
    end
    out_ready_i = 1'b0;
    done_ok = done_o;
    @(negedge clk);
    done_ok = done_ok && !done_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready_o, out_valid_o, busy_o, done_o} !== 4'b0 || out_data_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b done=%b data=%h, required all 0",
               in_ready_o, out_valid_o, busy_o, done_o, out_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_single_tile;
    bit rok, fov, sok, dok, to;
    logic [AW-1:0] expv [2][COL];
    for (int c = 0; c < COL; c++) begin
      stim[0][0][c] = AW'(c + 1);
      stim[0][1][c] = AW'(c + 4);
      expv[0][c] = AW'(c + 1);
      expv[1][c] = AW'(c + 4);
    end
    run_job(2, 1, 1'b0, 1'b0, rok, fov, sok, dok, to);
    total++;
    if (to || !rok || !fov || !dok || got_q.size() != 2) begin
      bad++;
      $display("FAIL single_tile_flow: got timeout=%b ready=%b first_ov=%b done=%b rows=%0d, required 0 1 1 1 2",
               to, rok, fov, dok, got_q.size());
    end
    for (int r = 0; r < got_q.size() && r < 2; r++)
      for (int c = 0; c < COL; c++) begin
        total++;
        if (got_q[r][c] !== expv[r][c]) begin
          bad++;
          $display("FAIL single_tile_data r%0d c%0d: got %h, required %h", r, c, got_q[r][c], expv[r][c]);
        end
      end
    $display("test_single_tile: rows=%0d", got_q.size());
  endtask

  task automatic test_multi_tile;
    bit rok, fov, sok, dok, to;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < COL; c++) begin
        stim[k][0][c] = 16'd1;
        stim[k][1][c] = 16'd2;
      end
    run_job(2, 3, 1'b0, 1'b0, rok, fov, sok, dok, to);
    total++;
    if (to || !fov || !dok || got_q.size() != 2) begin
      bad++;
      $display("FAIL multi_tile_flow: got timeout=%b first_ov=%b done=%b rows=%0d, required 0 1 1 2",
               to, fov, dok, got_q.size());
    end
    for (int r = 0; r < got_q.size() && r < 2; r++)
      for (int c = 0; c < COL; c++) begin
        total++;
        if (got_q[r][c] !== AW'(3 * (r + 1))) begin
          bad++;
          $display("FAIL multi_tile_data r%0d c%0d: got %h, required %h", r, c, got_q[r][c], AW'(3 * (r + 1)));
        end
      end
    $display("test_multi_tile: rows=%0d", got_q.size());
  endtask

  task automatic test_random_backpressure;
    bit rok, fov, sok, dok, to;
    int m, t, e;
    for (int it = 0; it < 5; it++) begin
      m = $urandom_range(1, DEPTH);
      t = $urandom_range(1, MAXT);
      for (int k = 0; k < MAXT; k++)
        for (int r = 0; r < DEPTH; r++)
          for (int c = 0; c < COL; c++) stim[k][r][c] = AW'($urandom);
      run_job(m, t, 1'b1, 1'b1, rok, fov, sok, dok, to);
      total++;
      if (to || !rok || !sok || !dok || got_q.size() != m) begin
        bad++;
        $display("FAIL rand_flow it%0d: got timeout=%b ready=%b stable=%b done=%b rows=%0d, required 0 1 1 1 %0d",
                 it, to, rok, sok, dok, got_q.size(), m);
      end
      for (int r = 0; r < got_q.size() && r < m; r++)
        for (int c = 0; c < COL; c++) begin
          e = model_elem(t, r, c);
          total++;
          if (got_q[r][c] !== e[AW-1:0]) begin
            bad++;
            $display("FAIL rand_data it%0d r%0d c%0d: got %h, required %h", it, r, c, got_q[r][c], e[AW-1:0]);
          end
        end
      $display("test_random_backpressure: it=%0d m=%0d t=%0d rows=%0d", it, m, t, got_q.size());
    end
  endtask

  task automatic test_overflow;
    bit rok, fov, sok, dok, to;
    logic [AW-1:0] exp0, exp1;
`ifdef SA_PSUM_SAT_EN
    exp0 = 16'h7FFF; exp1 = 16'h8000;
`else
    exp0 = 16'h8000; exp1 = 16'h7FFF;
`endif
    for (int c = 0; c < COL; c++) begin
      stim[0][0][c] = 16'h7FFF; stim[1][0][c] = 16'h0001;
      stim[0][1][c] = 16'h8000; stim[1][1][c] = 16'hFFFF;
    end
    run_job(2, 2, 1'b0, 1'b0, rok, fov, sok, dok, to);
    total++;
    if (to || got_q.size() != 2) begin
      bad++;
      $display("FAIL overflow_flow: got timeout=%b rows=%0d, required 0 2", to, got_q.size());
    end
    for (int c = 0; c < COL && got_q.size() == 2; c++) begin
      total++;
      if (got_q[0][c] !== exp0 || got_q[1][c] !== exp1) begin
        bad++;
        $display("FAIL overflow_data c%0d: got %h/%h, required %h/%h", c, got_q[0][c], got_q[1][c], exp0, exp1);
      end
    end
    $display("test_overflow: rows=%0d", got_q.size());
  endtask

  task automatic test_zero_size;
    bit saw_rdy;
    for (int z = 0; z < 2; z++) begin
      @(negedge clk);
      start_i = 1'b1;
      num_rows_i  = (z == 0) ? RW'(0) : RW'(3);
      num_tiles_i = (z == 0) ? TILE_W'(2) : TILE_W'(0);
      @(negedge clk);
      start_i = 1'b0;
      saw_rdy = in_ready_o;
      total++;
      if (done_o !== 1'b1) begin
        bad++;
        $display("FAIL zero_done_pulse z%0d: got done=%b, required 1", z, done_o);
      end
      @(negedge clk);
      saw_rdy = saw_rdy || in_ready_o;
      total++;
      if (done_o !== 1'b0 || saw_rdy || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL zero_after z%0d: got done=%b rdy_seen=%b busy=%b, required 0 0 0", z, done_o, saw_rdy, busy_o);
      end
      $display("test_zero_size: case %0d", z);
    end
  endtask

  task automatic test_reset_mid;
    bit rok, fov, sok, dok, to;
    int e;
    @(negedge clk);
    start_i = 1'b1; num_rows_i = RW'(4); num_tiles_i = TILE_W'(1);
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = {16'd9, 16'd8, 16'd7};
    @(negedge clk);
    in_valid_i = 1'b0; rst_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; start_i = 1'b0;
    total++;
    if ({in_ready_o, out_valid_o, busy_o, done_o} !== 4'b0 || out_data_o !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b ov=%b busy=%b done=%b, required all 0",
               in_ready_o, out_valid_o, busy_o, done_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || in_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_idle cyc%0d: got done=%b rdy=%b, required 0 0", i, done_o, in_ready_o);
      end
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < COL; c++) stim[k][r][c] = AW'($urandom_range(0, 1000));
    run_job(4, 2, 1'b1, 1'b0, rok, fov, sok, dok, to);
    total++;
    if (to || !dok || got_q.size() != 4) begin
      bad++;
      $display("FAIL reset_mid_rerun: got timeout=%b done=%b rows=%0d, required 0 1 4", to, dok, got_q.size());
    end
    for (int r = 0; r < got_q.size() && r < 4; r++)
      for (int c = 0; c < COL; c++) begin
        e = model_elem(2, r, c);
        total++;
        if (got_q[r][c] !== e[AW-1:0]) begin
          bad++;
          $display("FAIL reset_mid_data r%0d c%0d: got %h, required %h", r, c, got_q[r][c], e[AW-1:0]);
        end
      end
    $display("test_reset_mid: rerun rows=%0d", got_q.size());
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_random_backpressure();
    test_overflow();
    test_zero_size();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
